// File: rtl/uart_ram_programmer.sv
// Serial program loader: waits for a magic byte sequence on an 8N1 line, then
// writes a little-endian word count and that many words into RAM, holding the system in reset.
module uart_ram_programmer #(
   parameter int                        CLK_FREQ     = 50_000_000,
   parameter int                        BAUD_RATE    = 115_200,
   parameter int                        SEQ_LENGTH   = 8,
   parameter logic [8*SEQ_LENGTH-1:0]   MAGIC_SEQ    = "CERESTST",
   parameter int                        BREAK_CYCLES = 1_000_000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        uart_rx_i,
   output logic [31:0] prog_addr_o,
   output logic [31:0] prog_data_o,
   output logic        prog_valid_o,
   output logic        prog_mode_o,
   output logic        system_reset_o
);

   localparam int              CPB      = CLK_FREQ / BAUD_RATE;
   localparam int              CW       = $clog2(CPB);
   localparam logic [CW-1:0]   BIT_M1   = CW'(CPB - 1);
   localparam logic [CW-1:0]   HALF_M1  = CW'(CPB / 2 - 1);
   localparam int              IW       = (SEQ_LENGTH > 1) ? $clog2(SEQ_LENGTH) : 1;
   localparam logic [IW-1:0]   IDX_LAST = IW'(SEQ_LENGTH - 1);
   localparam logic [31:0]     BREAK    = 32'(BREAK_CYCLES);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DATA, S_DONE} state_t;

   // Index 0 is the first byte on the wire, i.e. the leftmost string character.
   function automatic logic [7:0] magic_byte(input int i);
      return MAGIC_SEQ[8*(SEQ_LENGTH-1-i) +: 8];
   endfunction

   rx_state_t     rx_state, rx_next;
   logic [1:0]    rx_sync;
   logic          rx_s;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    rx_byte;
   logic          byte_valid;

   assign rx_s = rx_sync[1];

   always_ff @(posedge clk_i) begin
      if (rst_i) rx_state <= RX_IDLE;
      else       rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:  if (!rx_s) rx_next = RX_START;
         RX_START: if (rx_cnt == HALF_M1) rx_next = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_cnt == BIT_M1 && bit_idx == 3'd7) rx_next = RX_STOP;
         RX_STOP:  if (rx_cnt == BIT_M1) rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_sync    <= 2'b11;
         rx_cnt     <= '0;
         bit_idx    <= '0;
         rx_byte    <= '0;
         byte_valid <= 1'b0;
      end else begin
         rx_sync    <= {rx_sync[0], uart_rx_i};
         byte_valid <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               rx_cnt  <= '0;
               bit_idx <= '0;
            end
            RX_START: rx_cnt <= (rx_cnt == HALF_M1) ? '0 : rx_cnt + 1'b1;
            RX_DATA: begin
               if (rx_cnt == BIT_M1) begin
                  rx_cnt  <= '0;
                  rx_byte <= {rx_s, rx_byte[7:1]};
                  bit_idx <= bit_idx + 1'b1;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == BIT_M1) begin
                  rx_cnt     <= '0;
                  byte_valid <= rx_s;  // stop bit low: framing error, byte dropped
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: rx_cnt <= '0;
         endcase
      end
   end

   state_t        state, state_next;
   logic [IW-1:0] idx;
   logic [1:0]    byte_cnt;
   logic [31:0]   shreg, assembled, words_left, addr, timer;
   logic          timeout;

   assign assembled = {rx_byte, shreg[31:8]};
   assign timeout   = (timer == BREAK);

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:
            if (byte_valid && rx_byte == magic_byte(int'(idx)) && idx == IDX_LAST)
               state_next = S_COUNT;
         S_COUNT:
            if (timeout) state_next = S_IDLE;
            else if (byte_valid && byte_cnt == 2'd3)
               state_next = (assembled == 32'd0) ? S_DONE : S_DATA;
         S_DATA:
            if (timeout) state_next = S_IDLE;
            else if (byte_valid && byte_cnt == 2'd3 && words_left == 32'd1)
               state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx          <= '0;
         byte_cnt     <= '0;
         shreg        <= '0;
         words_left   <= '0;
         addr         <= '0;
         timer        <= '0;
         prog_addr_o  <= '0;
         prog_data_o  <= '0;
         prog_valid_o <= 1'b0;
      end else begin
         prog_valid_o <= 1'b0;
         case (state)
            S_IDLE: begin
               byte_cnt <= '0;
               timer    <= '0;
               if (byte_valid) begin
                  if (rx_byte == magic_byte(int'(idx)))
                     idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                  else
                     idx <= (rx_byte == magic_byte(0)) ? IW'(1) : '0;
               end
            end
            S_COUNT, S_DATA: begin
               timer <= byte_valid ? 32'd0 : timer + 32'd1;
               if (byte_valid && !timeout) begin
                  shreg    <= assembled;
                  byte_cnt <= byte_cnt + 1'b1;
                  if (byte_cnt == 2'd3) begin
                     if (state == S_COUNT) begin
                        words_left <= assembled;
                        addr       <= '0;
                     end else begin
                        prog_valid_o <= 1'b1;
                        prog_data_o  <= assembled;
                        prog_addr_o  <= addr;
                        addr         <= addr + 32'd1;
                        words_left   <= words_left - 32'd1;
                     end
                  end
               end
            end
            default: idx <= '0;
         endcase
      end
   end

   // Mode stays up through DONE so the last strobe is covered.
   assign prog_mode_o    = (state != S_IDLE);
   assign system_reset_o = (state != S_IDLE);

endmodule

// File: tb/tb_uart_ram_programmer.sv
// Bench for uart_ram_programmer: serial byte driver, expected-write queue
// checked on every strobe, and session-level checks of the mode outputs.
module tb_uart_ram_programmer;

  localparam int CPB = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [31:0] prog_addr, prog_data;
  logic        prog_valid, prog_mode, system_reset;

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;
  logic [63:0] exp_q[$];

  uart_ram_programmer #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .SEQ_LENGTH(2),
    .MAGIC_SEQ("AB"), .BREAK_CYCLES(2000)
  ) dut (
    .clk_i(clk), .rst_i(rst), .uart_rx_i(rx),
    .prog_addr_o(prog_addr), .prog_data_o(prog_data), .prog_valid_o(prog_valid),
    .prog_mode_o(prog_mode), .system_reset_o(system_reset)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(CPB);
    end
    rx = stop_bit;
    wait_clks(CPB);
    rx = 1'b1;
    wait_clks(4);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic send_magic();
    send_byte("A", 1'b1);
    send_byte("B", 1'b1);
  endtask

  task automatic check_mode(input string tag, input logic exp);
    check_eq({tag, "_mode"}, 64'(prog_mode), 64'(exp));
    check_eq({tag, "_sysrst"}, 64'(system_reset), 64'(exp));
  endtask

  // Scoreboard: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && prog_valid) begin
      strobes++;
      check_eq("strobe_in_mode", 64'(prog_mode), 64'd1);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_strobe", {prog_addr, prog_data}, 64'd0);
      end else begin
        check_eq("write", {prog_addr, prog_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int strobes_before;

    // Reset and idle
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(1);
    check_mode("reset", 1'b0);
    check_eq("reset_valid", 64'(prog_valid), 64'd0);
    check_eq("reset_addr", 64'(prog_addr), 64'd0);
    check_eq("reset_data", 64'(prog_data), 64'd0);
    wait_clks(500);
    check_mode("idle", 1'b0);
    check_eq("idle_strobes", 64'(strobes), 64'd0);

    // Full two-word load
    send_byte("A", 1'b1);
    check_mode("after_a", 1'b0);
    send_byte("B", 1'b1);
    check_mode("after_b", 1'b1);
    exp_q.push_back({32'd0, 32'h12345678});
    exp_q.push_back({32'd1, 32'hDEADBEEF});
    send_word(32'd2);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    check_mode("load_end", 1'b0);
    check_eq("load_strobes", 64'(strobes), 64'd2);
    check_eq("load_q_empty", 64'(exp_q.size()), 64'd0);
    check_eq("addr_hold", 64'(prog_addr), 64'd1);
    check_eq("data_hold", 64'(prog_data), 64'hDEADBEEF);

    // Restart on repeated first byte, then zero count closes the session
    send_byte("A", 1'b1);
    send_byte("A", 1'b1);
    send_byte("B", 1'b1);
    check_mode("aab", 1'b1);
    strobes_before = strobes;
    send_word(32'd0);
    check_mode("zero_count", 1'b0);
    check_eq("zero_strobes", 64'(strobes), 64'(strobes_before));

    send_byte("A", 1'b1);
    send_byte("X", 1'b1);
    send_byte("B", 1'b1);
    check_mode("axb", 1'b0);

    // Timeout mid-word, then a fresh session restarts at address 0
    send_magic();
    send_word(32'd1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    strobes_before = strobes;
    wait_clks(1970);
    check_mode("before_timeout", 1'b1);
    wait_clks(50);
    check_mode("after_timeout", 1'b0);
    check_eq("timeout_strobes", 64'(strobes), 64'(strobes_before));

    send_magic();
    send_word(32'd3);
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      exp_q.push_back({32'(i), w});
      send_word(w);
    end
    check_mode("random_end", 1'b0);
    check_eq("random_q_empty", 64'(exp_q.size()), 64'd0);

    // Framing error inside the magic sequence is ignored
    send_byte("A", 1'b1);
    send_byte("B", 1'b0);
    wait_clks(30);
    check_mode("framing_bad", 1'b0);
    send_byte("B", 1'b1);
    check_mode("framing_good", 1'b1);
    send_word(32'd0);
    check_mode("framing_close", 1'b0);

    // Short glitch between magic bytes produces no byte
    send_byte("A", 1'b1);
    rx = 1'b0;
    wait_clks(3);
    rx = 1'b1;
    wait_clks(30);
    send_byte("B", 1'b1);
    check_mode("glitch", 1'b1);

    // Reset mid-session clears everything
    send_byte(8'h05, 1'b1);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    check_mode("mid_reset", 1'b0);
    check_eq("mid_reset_addr", 64'(prog_addr), 64'd0);
    check_eq("mid_reset_data", 64'(prog_data), 64'd0);
    wait_clks(20);

    check_eq("total_strobes", 64'(strobes), 64'd5);
    check_eq("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_ram_programmer.md
Name: uart_ram_programmer

Overview:
UART-driven loader that writes a program image into the system RAM over a serial line. It listens on a dedicated RX pin for a magic byte sequence, then receives a 32-bit word count followed by that many 32-bit words. Each word is issued as a one-cycle write request at incrementing word addresses. While loading, it holds the rest of the system in reset; it sits inside the RAM wrapper, ahead of the RAM bank write muxes.

Parameters:
- CLK_FREQ, 50_000_000: clock frequency in Hz.
- BAUD_RATE, 115_200: UART bit rate. CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division, must be ≥ 4).
- SEQ_LENGTH, 8: number of bytes in the magic sequence (≥ 1).
- MAGIC_SEQ, "CERESTST" (8*SEQ_LENGTH bits): magic bytes. The first byte expected on the wire is MAGIC_SEQ[8*SEQ_LENGTH-1 -: 8] (string order, MSB byte first).
- BREAK_CYCLES, 1_000_000: inactivity timeout in clocks while loading.

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: synchronous active-high reset.
- uart_rx_i, input, 1: asynchronous serial input, idle high.
- prog_addr_o, output, 32: word address of the current write (0, 1, 2, …).
- prog_data_o, output, 32: write data.
- prog_valid_o, output, 1: one-cycle write strobe. Address and data are valid in the same cycle.
- prog_mode_o, output, 1: high while a load session is active.
- system_reset_o, output, 1: high to hold the CPU/system in reset.

Behaviour:
- Reset: all outputs are 0. FSM goes to IDLE, the match index clears, and the UART receiver goes idle.
- UART RX, 8N1, LSB first:
  - Input passes through a 2-flop synchronizer.
  - A start bit is detected on a synchronized low level while the receiver is idle. It is re-checked at CLKS_PER_BIT/2; if the line is high again, the start is a glitch and the receiver returns to idle.
  - Each data bit is sampled every CLKS_PER_BIT clocks after that midpoint.
  - The stop bit is sampled the same way. If the stop bit is 1, the receiver gives a one-cycle byte_valid with the data. If the stop bit is 0, the byte is dropped.
- FSM state IDLE:
  - Each received byte is compared with MAGIC_SEQ[idx].
  - On a match, idx increments. On a mismatch, idx becomes 1 if the byte equals MAGIC_SEQ[0], otherwise 0.
  - When idx reaches SEQ_LENGTH, go to COUNT, clear idx, and assert prog_mode_o and system_reset_o on the next cycle.
- FSM state COUNT:
  - Collect 4 bytes, little-endian, into word_count.
  - If word_count == 0, go to DONE. Otherwise clear the address counter and go to DATA.
- FSM state DATA:
  - Collect 4 bytes, little-endian, per word.
  - One cycle after the 4th byte's byte_valid: prog_valid_o = 1 for exactly one cycle, prog_data_o = the assembled word, prog_addr_o = the current address.
  - The address then increments by 1.
  - After word_count words, go to DONE.
- FSM state DONE: lasts one cycle. prog_mode_o and system_reset_o drop to 0 on the following cycle, then the FSM returns to IDLE with idx = 0.
- Timeout: in COUNT or DATA, a counter resets on every byte_valid and increments otherwise. When it reaches BREAK_CYCLES:
  - Abort to IDLE.
  - Deassert prog_mode_o and system_reset_o.
  - Partial word and count are discarded; words already written stay written.
- Output holding:
  - prog_addr_o and prog_data_o hold their last values when prog_valid_o is low.
  - prog_valid_o is never high while prog_mode_o is low.
- Magic bytes received during COUNT or DATA are treated as data, not as a restart.
- Reset mid-session: rst_i immediately returns everything to the reset state on the next clock edge.

Test Plan:
Common setup: CLK_FREQ=1_000_000, BAUD_RATE=100_000 (10 clks/bit), SEQ_LENGTH=2, MAGIC_SEQ="AB", BREAK_CYCLES=2000.
- Reset: hold rst_i 3 cycles with RX high → all outputs 0. Idle for 500 clks → outputs remain 0.
- Full load: send "A","B", count 02 00 00 00, then 78 56 34 12 and EF BE AD DE →
  - prog_mode_o and system_reset_o rise after "B".
  - Two single-cycle strobes: (addr 0, 0x12345678) and (addr 1, 0xDEADBEEF).
  - Both mode outputs fall after the second word; exactly 2 strobes in total.
- Sequence restart: send "A","A","B" → session starts. Send "A","X","B" → no session.
- Zero count: magic then 00 00 00 00 → prog_mode_o pulses, with no prog_valid_o.
- Timeout: magic, count 1, then 2 data bytes, then silence → mode outputs fall 2000 clks after the last byte with no strobe. A following complete session starts again at addr 0.
- Framing error: a byte with stop bit 0 inside the magic sequence is ignored. A glitch shorter than CLKS_PER_BIT/2 on RX produces no byte.
